core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences the fetch, decode, execute, memory and writeback phases by issuing one-cycle phase strobes to the pipeline stage blocks, including C_DECODE to the decode stage. Handles the instruction- and data-memory request/acknowledge handshakes and keeps a retired-instruction counter. Sits beside the datapath in the core top level.

---
 rtl/core_sequencer_pkg.sv | 44 ++++
 rtl/core_sequencer_if.sv | 30 +++
 rtl/core_opclass.sv | 39 +++
 rtl/core_sequencer.sv | 127 ++++++++++++
 tb/tb_core_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg
//   Shared constants and types for the RV32I multi-cycle sequencer.
//   - OPCODE_* : RV32I major opcodes (instruction[6:0]), the same values the
//                decode stage uses.
//   - SEQ_ST_* : 3-bit state encodings of the sequencer FSM.
//   - op_class_t : per-instruction classification captured in DECODE.
package core_sequencer_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [2:0] SEQ_ST_FETCH     = 3'd0;
  localparam logic [2:0] SEQ_ST_DECODE    = 3'd1;
  localparam logic [2:0] SEQ_ST_EXECUTE   = 3'd2;
  localparam logic [2:0] SEQ_ST_MEMORY    = 3'd3;
  localparam logic [2:0] SEQ_ST_WRITEBACK = 3'd4;
  localparam logic [2:0] SEQ_ST_TRAP      = 3'd5;

  typedef enum logic [2:0] {
    ST_FETCH     = SEQ_ST_FETCH,
    ST_DECODE    = SEQ_ST_DECODE,
    ST_EXECUTE   = SEQ_ST_EXECUTE,
    ST_MEMORY    = SEQ_ST_MEMORY,
    ST_WRITEBACK = SEQ_ST_WRITEBACK,
    ST_TRAP      = SEQ_ST_TRAP
  } seq_state_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic writes_rd;
    logic legal;
  } op_class_t;

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if
//   Instruction- and data-memory request/acknowledge handshake between the
//   sequencer and the memory side.
//   - IMEM_REQ / IMEM_ACK : instruction fetch request / word valid
//   - DMEM_REQ / DMEM_ACK : data access request / access complete
//   - DMEM_WE             : data access is a store (valid with DMEM_REQ)
//   Modports: master = sequencer, slave = memory side.
interface core_sequencer_if;
  logic IMEM_REQ;
  logic IMEM_ACK;
  logic DMEM_REQ;
  logic DMEM_ACK;
  logic DMEM_WE;

  modport master (
    output IMEM_REQ,
    output DMEM_REQ,
    output DMEM_WE,
    input  IMEM_ACK,
    input  DMEM_ACK
  );

  modport slave (
    input  IMEM_REQ,
    input  DMEM_REQ,
    input  DMEM_WE,
    output IMEM_ACK,
    output DMEM_ACK
  );
endinterface

// File: rtl/core_opclass.sv
// core_opclass
//   Combinational RV32I opcode classifier used by the sequencer.
//   Ports:
//     opcode (in, 7)  instruction[6:0]
//     cls    (out)    {is_load, is_store, writes_rd, legal}
//   FENCE and SYSTEM are legal but behave as NOPs (no memory, no rd write).
//   Anything unrecognised is illegal with every other flag clear.
module core_opclass
  import core_sequencer_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPCODE_LOAD: begin
        cls.is_load   = 1'b1;
        cls.writes_rd = 1'b1;
        cls.legal     = 1'b1;
      end
      OPCODE_STORE: begin
        cls.is_store = 1'b1;
        cls.legal    = 1'b1;
      end
      OPCODE_OP, OPCODE_OPIMM, OPCODE_LUI, OPCODE_AUIPC,
      OPCODE_JAL, OPCODE_JALR: begin
        cls.writes_rd = 1'b1;
        cls.legal     = 1'b1;
      end
      OPCODE_BRANCH, OPCODE_FENCE, OPCODE_SYSTEM: begin
        cls.legal = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
//   Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXECUTE
//   -> [MEMORY] -> WRITEBACK, one-cycle phase strobes to the stage blocks,
//   memory handshakes and a retired-instruction counter.
//   Optional feature macro: CORE_TRAP_EN (illegal opcode -> sticky TRAP
//   state; when undefined an illegal opcode retires as a NOP).
//   Ports:
//     CLK          in   core clock (rising edge)
//     NRST         in   synchronous active-low reset; forces outputs to 0
//     OPCODE       in   7  instruction[6:0], sampled in DECODE only
//     mem          master modport of core_sequencer_if (IMEM/DMEM handshake)
//     C_FETCH .. C_WRITEBACK  out  one-cycle phase strobes
//     REG_WE       out  register-file write enable (with C_WRITEBACK)
//     PC_UPDATE    out  PC load enable (with C_WRITEBACK)
//     TRAP         out  illegal-opcode trap indication
//     INSTRET      out  32  retired-instruction count
module core_sequencer
  import core_sequencer_pkg::*;
(
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [6:0]              OPCODE,
  core_sequencer_if.master        mem,
  output logic                    C_FETCH,
  output logic                    C_DECODE,
  output logic                    C_EXECUTE,
  output logic                    C_MEMORY,
  output logic                    C_WRITEBACK,
  output logic                    REG_WE,
  output logic                    PC_UPDATE,
  output logic                    TRAP,
  output logic [31:0]             INSTRET
);

  seq_state_e  state;
  op_class_t   cls_dec;
  op_class_t   cls_q;
  logic [31:0] instret_q;

  core_opclass u_opclass (
    .opcode (OPCODE),
    .cls    (cls_dec)
  );

  // State register, captured classification and retire counter
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state     <= ST_FETCH;
      cls_q     <= '0;
      instret_q <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem.IMEM_ACK) state <= ST_DECODE;
        end
        ST_DECODE: begin
          cls_q <= cls_dec;
`ifdef CORE_TRAP_EN
          if (!cls_dec.legal) state <= ST_TRAP;
          else                state <= ST_EXECUTE;
`else
          state <= ST_EXECUTE;
`endif
        end
        ST_EXECUTE: begin
          state <= (cls_q.is_load || cls_q.is_store) ? ST_MEMORY : ST_WRITEBACK;
        end
        ST_MEMORY: begin
          if (mem.DMEM_ACK) state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          instret_q <= instret_q + 32'd1;
          state     <= ST_FETCH;
        end
`ifdef CORE_TRAP_EN
        ST_TRAP: state <= ST_TRAP;  // sticky until reset
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Output decode: Moore from state, except C_FETCH / C_MEMORY which are
  // gated by the acknowledge. Everything is held low while NRST is low so a
  // pending request drops in the very cycle reset is asserted.
  always_comb begin
    mem.IMEM_REQ = 1'b0;
    mem.DMEM_REQ = 1'b0;
    mem.DMEM_WE  = 1'b0;
    C_FETCH      = 1'b0;
    C_DECODE     = 1'b0;
    C_EXECUTE    = 1'b0;
    C_MEMORY     = 1'b0;
    C_WRITEBACK  = 1'b0;
    REG_WE       = 1'b0;
    PC_UPDATE    = 1'b0;
    TRAP         = 1'b0;
    if (NRST) begin
      case (state)
        ST_FETCH: begin
          mem.IMEM_REQ = 1'b1;
          C_FETCH      = mem.IMEM_ACK;
        end
        ST_DECODE:  C_DECODE  = 1'b1;
        ST_EXECUTE: C_EXECUTE = 1'b1;
        ST_MEMORY: begin
          mem.DMEM_REQ = 1'b1;
          mem.DMEM_WE  = cls_q.is_store;
          C_MEMORY     = mem.DMEM_ACK;
        end
        ST_WRITEBACK: begin
          C_WRITEBACK = 1'b1;
          PC_UPDATE   = 1'b1;
          // illegal opcodes retiring as NOPs never write rd
          REG_WE      = cls_q.writes_rd & cls_q.legal;
        end
`ifdef CORE_TRAP_EN
        ST_TRAP: TRAP = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign INSTRET = NRST ? instret_q : 32'd0;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
//   Self-checking bench for core_sequencer. A phase-level reference model
//   builds the expected per-cycle output pattern of each instruction from its
//   opcode class and the memory wait counts, then compares it against the DUT.
//   Honours CORE_TRAP_EN the same way as the design.
module tb_core_sequencer;

  logic        CLK;
  logic        NRST;
  logic [6:0]  OPCODE;
  logic        C_FETCH, C_DECODE, C_EXECUTE, C_MEMORY, C_WRITEBACK;
  logic        REG_WE, PC_UPDATE, TRAP;
  logic [31:0] INSTRET;

  core_sequencer_if mem ();

  core_sequencer dut (
    .CLK         (CLK),
    .NRST        (NRST),
    .OPCODE      (OPCODE),
    .mem         (mem.master),
    .C_FETCH     (C_FETCH),
    .C_DECODE    (C_DECODE),
    .C_EXECUTE   (C_EXECUTE),
    .C_MEMORY    (C_MEMORY),
    .C_WRITEBACK (C_WRITEBACK),
    .REG_WE      (REG_WE),
    .PC_UPDATE   (PC_UPDATE),
    .TRAP        (TRAP),
    .INSTRET     (INSTRET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output vector bit masks
  localparam logic [10:0] B_IREQ = 11'h400;
  localparam logic [10:0] B_DREQ = 11'h200;
  localparam logic [10:0] B_DWE  = 11'h100;
  localparam logic [10:0] B_CF   = 11'h080;
  localparam logic [10:0] B_CD   = 11'h040;
  localparam logic [10:0] B_CE   = 11'h020;
  localparam logic [10:0] B_CM   = 11'h010;
  localparam logic [10:0] B_CW   = 11'h008;
  localparam logic [10:0] B_RWE  = 11'h004;
  localparam logic [10:0] B_PCU  = 11'h002;
  localparam logic [10:0] B_TRP  = 11'h001;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [10:0] outs;
  assign outs = {mem.IMEM_REQ, mem.DMEM_REQ, mem.DMEM_WE, C_FETCH, C_DECODE,
                 C_EXECUTE, C_MEMORY, C_WRITEBACK, REG_WE, PC_UPDATE, TRAP};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] instret_m = 32'd0;

  logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0001111, 7'b1110011};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {is_load, is_store, writes_rd, legal} from the RV32I opcode rules
  function automatic logic [3:0] ref_class(input logic [6:0] op);
    case (op)
      7'b0000011: return 4'b1011;
      7'b0100011: return 4'b0101;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111: return 4'b0011;
      7'b1100011, 7'b0001111, 7'b1110011: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic cyc(input logic [10:0] ev, input logic [6:0] opc,
                     input logic ai, input logic ad, input logic nr, input string tag);
    @(posedge CLK);
    #1;
    NRST         = nr;
    OPCODE       = opc;
    mem.IMEM_ACK = ai;
    mem.DMEM_ACK = ad;
    @(negedge CLK);
    check_eq(tag, 32'(outs), 32'(ev));
    check_eq({tag, "_instret"}, INSTRET, nr ? instret_m : 32'd0);
  endtask

  task automatic reset_dut();
    cyc(11'd0, rop(), rnd1(), rnd1(), 1'b0, "reset");
    cyc(11'd0, rop(), rnd1(), rnd1(), 1'b0, "reset");
    instret_m = 32'd0;
  endtask

  // Whole instruction: wi imem wait cycles, wd dmem wait cycles.
  task automatic run_instr(input logic [6:0] opc, input int wi, input int wd,
                           output logic trapped);
    logic [3:0] c;
    logic ld, st, wr, lg;
    c = ref_class(opc);
    {ld, st, wr, lg} = c;
    trapped = 1'b0;
    for (int i = 0; i <= wi; i++)
      cyc(B_IREQ | ((i == wi) ? B_CF : 11'd0), rop(), (i == wi), rnd1(), 1'b1, "fetch");
    cyc(B_CD, opc, rnd1(), rnd1(), 1'b1, "decode");
`ifdef CORE_TRAP_EN
    if (!lg) begin
      for (int i = 0; i < 4; i++)
        cyc(B_TRP, rop(), rnd1(), rnd1(), 1'b1, "trap");
      trapped = 1'b1;
      return;
    end
`endif
    cyc(B_CE, rop(), rnd1(), rnd1(), 1'b1, "execute");
    if (ld || st)
      for (int i = 0; i <= wd; i++)
        cyc(B_DREQ | (st ? B_DWE : 11'd0) | ((i == wd) ? B_CM : 11'd0),
            rop(), rnd1(), (i == wd), 1'b1, "memory");
    cyc(B_CW | B_PCU | ((wr && lg) ? B_RWE : 11'd0), rop(), rnd1(), rnd1(), 1'b1, "writeback");
    instret_m = instret_m + 32'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tr;
    NRST         = 1'b0;
    OPCODE       = 7'd0;
    mem.IMEM_ACK = 1'b0;
    mem.DMEM_ACK = 1'b0;

    reset_dut();

    // ADDI, zero-wait fetch: F,D,E,W on cycles 1..4
    run_instr(OP_ADDI, 0, 0, tr);
    // SW with three data-memory wait cycles
    run_instr(OP_SW, 0, 3, tr);
    // LW then BEQ
    run_instr(OP_LW, 1, 0, tr);
    run_instr(OP_BEQ, 0, 0, tr);
    // opcode 0000000: trap or NOP depending on build
    run_instr(7'b0000000, 0, 0, tr);
    if (tr) reset_dut();
    run_instr(OP_ADDI, 2, 0, tr);

    // Reset during a MEMORY wait with DMEM_ACK arriving in the same cycle
    cyc(B_IREQ | B_CF, rop(), 1'b1, 1'b0, 1'b1, "mr_fetch");
    cyc(B_CD, OP_SW, 1'b0, 1'b0, 1'b1, "mr_decode");
    cyc(B_CE, rop(), 1'b0, 1'b0, 1'b1, "mr_execute");
    cyc(B_DREQ | B_DWE, rop(), 1'b0, 1'b0, 1'b1, "mr_wait");
    cyc(11'd0, rop(), 1'b0, 1'b1, 1'b0, "mr_reset");
    instret_m = 32'd0;
    cyc(B_IREQ, rop(), 1'b0, 1'b1, 1'b1, "mr_release");
    run_instr(OP_LW, 0, 1, tr);

    // INSTRET wrap: preload FFFFFFFF during a fetch wait, then retire one
    cyc(B_IREQ, rop(), 1'b0, rnd1(), 1'b1, "wrap_wait");
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    instret_m = 32'hFFFF_FFFF;
    run_instr(OP_ADDI, 0, 0, tr);
    cyc(B_IREQ, rop(), 1'b0, rnd1(), 1'b1, "wrap_after");

    // Randomised instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 7) == 0) op = rop();
      else                           op = legal_ops[$urandom_range(0, 10)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), tr);
      if (tr) reset_dut();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
